// File: rtl/count_down_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_down_pkg
// Brief    : Shared state encoding and default width for count_down_timer.
// Revision : 1.0
// ============================================================================
package count_down_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_EXPIRED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/count_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : count_down_timer
// Brief    : Loadable one-shot / periodic down-counter with pause and abort.
// Revision : 1.0
// ============================================================================
module count_down_timer
    import count_down_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    localparam logic [WIDTH-1:0] c_count_one = WIDTH'(1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_EXPIRED: begin
                if (load_valid) begin
                    reload_d = load_value;
                    count_d  = load_value;
                    // A zero load terminates immediately, regardless of mode
                    if (load_value == '0) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    if (count_q == c_count_one) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_EXPIRED;
                        end
                    end else begin
                        count_d = count_q - c_count_one;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        load_ready = (state_q != ST_RUN);
        busy       = (state_q == ST_RUN);
        expired    = (state_q == ST_EXPIRED);
        count      = count_q;
        done       = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_count_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_down_timer
// Brief    : Scoreboard bench for count_down_timer with randomized trials.
// Revision : 1.0
// ============================================================================
module tb_count_down_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_value;
    logic       load_ready;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       expired;

    count_down_timer #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        bit         busy;
        bit         expd;
        bit         done;
        bit         rdy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic void push(input string tag, input int c, input int cnt,
                                 input bit b, input bit e, input bit d);
        exp_t x;
        x.cyc  = c;
        x.cnt  = cnt[7:0];
        x.busy = b;
        x.expd = e;
        x.done = d;
        x.rdy  = !b;
        x.tag  = $sformatf("%s_c%0d", tag, c);
        sb.push_back(x);
    endfunction

    // Monitor: registered outputs are compared against the expected snapshot for this cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc)
                check({e.tag, "_missed"}, cyc, e.cyc);
            else
                check(e.tag, {count, busy, expired, done, load_ready},
                      {e.cnt, e.busy, e.expd, e.done, e.rdy});
        end
    end

    // One load followed by len edges of stimulus; ar_mode 2 randomizes auto_reload per edge.
    task automatic trial(input string tag, input int n, input int ar_mode, input int len,
                         input int abort_at, input int pz_lo, input int pz_hi,
                         input int pause_pct, input bit keep_running);
        bit         pz_a[], ab_a[], ar_a[], lv_a[];
        logic [7:0] lvv_a[];
        bit         running, expd, dn;
        int         cnt, a;
        pz_a = new[len+1]; ab_a = new[len+1]; ar_a = new[len+1];
        lv_a = new[len+1]; lvv_a = new[len+1];
        @(negedge clk);
        a       = cyc + 1;
        running = (n > 0);
        expd    = (n == 0);
        cnt     = n;
        push(tag, a, cnt, running, expd, n == 0);
        for (int j = 1; j <= len; j++) begin
            pz_a[j]  = (j >= pz_lo && j <= pz_hi) || ($urandom_range(0, 99) < pause_pct);
            ar_a[j]  = (ar_mode == 2) ? ($urandom_range(0, 1) == 1) : (ar_mode == 1);
            ab_a[j]  = (j == abort_at) || (!running && $urandom_range(0, 3) == 0)
                       || (j == len && running && !keep_running);
            lv_a[j]  = running && ($urandom_range(0, 1) == 1);
            lvv_a[j] = 8'($urandom);
            dn = 1'b0;
            if (running) begin
                if (ab_a[j]) begin
                    running = 1'b0;
                    cnt     = 0;
                end else if (!pz_a[j]) begin
                    if (cnt == 1) begin
                        dn = 1'b1;
                        if (ar_a[j]) cnt = n;
                        else begin
                            cnt     = 0;
                            running = 1'b0;
                            expd    = 1'b1;
                        end
                    end else begin
                        cnt = cnt - 1;
                    end
                end
            end
            push(tag, a + j, cnt, running, expd, dn);
        end
        load_valid = 1'b1; load_value = n[7:0]; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            load_valid  = lv_a[j];
            load_value  = lvv_a[j];
            pause       = pz_a[j];
            abort       = ab_a[j];
            auto_reload = ar_a[j];
        end
        @(negedge clk);
        load_valid = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len, ab_at;
        reset = 1'b0; load_valid = 1'b0; load_value = '0;
        auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {count, busy, expired, done, load_ready}, {8'd0, 4'b0001});
        #2 reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", load_ready, 1'b1);

        trial("oneshot5",  5,   0, 8,   0, 0, -1, 0, 1'b0);
        trial("auto3",     3,   1, 13,  0, 0, -1, 0, 1'b0);
        trial("pause4",    4,   0, 8,   0, 3, 4,  0, 1'b0);
        trial("abort6",    6,   0, 6,   4, 0, -1, 0, 1'b0);
        trial("abortpz6",  6,   0, 8,   6, 6, 6,  0, 1'b0);
        trial("zero",      0,   1, 3,   0, 0, -1, 0, 1'b0);
        trial("max255",    255, 0, 258, 0, 0, -1, 0, 1'b0);
        trial("rst20",     20,  1, 13,  0, 0, -1, 0, 1'b1);

        // Count is 7 here; reset lands mid-cycle and must act without a clock edge
        #2 reset = 1'b0;
        #1 check("async_reset", {count, busy, expired, done, load_ready}, {8'd0, 4'b0001});
        @(negedge clk);
        check("reset_hold_no_done", {count, done}, {8'd0, 1'b0});
        #2 reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset2", load_ready, 1'b1);

        for (int t = 0; t < 25; t++) begin
            n     = $urandom_range(0, 12);
            len   = 2 * n + 4;
            ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            trial($sformatf("rnd%0d", t), n, $urandom_range(0, 2), len, ab_at, 0, -1, 25, 1'b0);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
